// File: rtl/vga_pkg.sv
// Shared types, standard video mode timings and helpers for the VGA scan-out engine.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int VGA640_H_VIS  = 640;
  localparam int VGA640_H_FP   = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP   = 48;
  localparam int VGA640_V_VIS  = 480;
  localparam int VGA640_V_FP   = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP   = 33;
  localparam bit VGA640_HS_POL = 1'b0;
  localparam bit VGA640_VS_POL = 1'b0;

  // 640x400 DOS text-mode variant shares the horizontal timing of 640x480
  localparam int DOS400_V_VIS  = 400;
  localparam int DOS400_V_FP   = 12;
  localparam int DOS400_V_SYNC = 2;
  localparam int DOS400_V_BP   = 35;
  localparam bit DOS400_HS_POL = 1'b0;
  localparam bit DOS400_VS_POL = 1'b1;

  function automatic int calc_tot(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with raw (undelayed) visible/sync flags and frame_start.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = VGA640_H_VIS,
  parameter int H_FP   = VGA640_H_FP,
  parameter int H_SYNC = VGA640_H_SYNC,
  parameter int H_BP   = VGA640_H_BP,
  parameter int V_VIS  = VGA640_V_VIS,
  parameter int V_FP   = VGA640_V_FP,
  parameter int V_SYNC = VGA640_V_SYNC,
  parameter int V_BP   = VGA640_V_BP,
  parameter int HC_W   = $clog2(calc_tot(H_VIS, H_FP, H_SYNC, H_BP)),
  parameter int VC_W   = $clog2(calc_tot(V_VIS, V_FP, V_SYNC, V_BP))
) (
  input  logic            i_clock,
  input  logic            i_reset,
  output logic [HC_W-1:0] o_hcnt,
  output logic [VC_W-1:0] o_vcnt,
  output logic            o_visible,
  output logic            o_hsAct,
  output logic            o_vsAct,
  output logic            o_lineEnd,
  output logic            o_frameEnd,
  output logic            o_frameStart
);

  localparam int H_TOT = calc_tot(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = calc_tot(V_VIS, V_FP, V_SYNC, V_BP);

  // One extra bit so sync ends equal to the total still compare correctly
  localparam logic [HC_W:0] H_VIS_C  = (HC_W+1)'(H_VIS);
  localparam logic [HC_W:0] HS_START = (HC_W+1)'(H_VIS + H_FP);
  localparam logic [HC_W:0] HS_END   = (HC_W+1)'(H_VIS + H_FP + H_SYNC);
  localparam logic [HC_W:0] H_LAST   = (HC_W+1)'(H_TOT - 1);
  localparam logic [VC_W:0] V_VIS_C  = (VC_W+1)'(V_VIS);
  localparam logic [VC_W:0] VS_START = (VC_W+1)'(V_VIS + V_FP);
  localparam logic [VC_W:0] VS_END   = (VC_W+1)'(V_VIS + V_FP + V_SYNC);
  localparam logic [VC_W:0] V_LAST   = (VC_W+1)'(V_TOT - 1);

  logic [HC_W-1:0] r_hcnt;
  logic [VC_W-1:0] r_vcnt;
  logic [HC_W:0]   w_hExt;
  logic [VC_W:0]   w_vExt;
  logic            w_lineEnd;
  logic            w_frameEnd;

  assign w_hExt     = {1'b0, r_hcnt};
  assign w_vExt     = {1'b0, r_vcnt};
  assign w_lineEnd  = (w_hExt == H_LAST);
  assign w_frameEnd = w_lineEnd && (w_vExt == V_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_lineEnd) begin
      r_hcnt <= '0;
      if (w_frameEnd) r_vcnt <= '0;
      else            r_vcnt <= r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign o_hcnt       = r_hcnt;
  assign o_vcnt       = r_vcnt;
  assign o_visible    = (w_hExt < H_VIS_C) && (w_vExt < V_VIS_C);
  assign o_hsAct      = (w_hExt >= HS_START) && (w_hExt < HS_END);
  assign o_vsAct      = (w_vExt >= VS_START) && (w_vExt < VS_END);
  assign o_lineEnd    = w_lineEnd;
  assign o_frameEnd   = w_frameEnd;
  // Gated by reset so the pulse is held off until the engine is released
  assign o_frameStart = !i_reset && (r_hcnt == '0) && (r_vcnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: timing, incremental framebuffer addressing and a pin-aligned RGB/sync/DE pipeline.
// Build option: define VGA_SCANLINE_EN to halve RGB on odd output rows.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VIS  = VGA640_H_VIS,
  parameter int H_FP   = VGA640_H_FP,
  parameter int H_SYNC = VGA640_H_SYNC,
  parameter int H_BP   = VGA640_H_BP,
  parameter int V_VIS  = VGA640_V_VIS,
  parameter int V_FP   = VGA640_V_FP,
  parameter int V_SYNC = VGA640_V_SYNC,
  parameter int V_BP   = VGA640_V_BP,
  parameter bit HS_POL = VGA640_HS_POL,
  parameter bit VS_POL = VGA640_VS_POL,
  parameter int SCALE  = 1,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 17
) (
  input  logic              CLOCK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [11:0]       fb_data,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              de,
  output logic              frame_start,
  output logic [9:0]        line
);

  localparam int H_TOT = calc_tot(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = calc_tot(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HC_W:0]       H_VLAST   = (HC_W+1)'(H_VIS - 1);
  localparam logic [SUB_W-1:0]    SUB_LAST  = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0]   LINE_STEP = ADDR_W'(H_VIS / SCALE);

  if ((SCALE != 1 && SCALE != 2 && SCALE != 4) || RD_LAT < 1 || RD_LAT > 3 ||
      (H_VIS % SCALE) != 0 || (V_VIS % SCALE) != 0 ||
      (64'(H_VIS / SCALE) * 64'(V_VIS / SCALE)) > (64'(1) << ADDR_W)) begin : g_paramErr
    $error("vga_scanout: illegal SCALE/RD_LAT/ADDR_W for the chosen resolution");
  end

  logic [HC_W-1:0] w_hcnt;
  logic [VC_W-1:0] w_vcnt;
  logic            w_visible;
  logic            w_hsAct;
  logic            w_vsAct;
  logic            w_lineEnd;
  logic            w_frameEnd;
  logic            w_frameStart;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HC_W(HC_W), .VC_W(VC_W)
  ) u_timing (
    .i_clock(CLOCK),
    .i_reset(RESET),
    .o_hcnt(w_hcnt),
    .o_vcnt(w_vcnt),
    .o_visible(w_visible),
    .o_hsAct(w_hsAct),
    .o_vsAct(w_vsAct),
    .o_lineEnd(w_lineEnd),
    .o_frameEnd(w_frameEnd),
    .o_frameStart(w_frameStart)
  );

  logic [ADDR_W-1:0] r_lineBase;
  logic [ADDR_W-1:0] r_pixAddr;
  logic [SUB_W-1:0]  r_hsub;
  logic [SUB_W-1:0]  r_vsub;

  // pix_addr is reloaded on the last cycle of each line so it already holds
  // line_base while hcnt=0; later assignments win, so frame wrap beats the advance.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_lineBase <= '0;
      r_pixAddr  <= '0;
      r_hsub     <= '0;
      r_vsub     <= '0;
    end else begin
      if (w_visible) begin
        if (r_hsub == SUB_LAST) begin
          r_pixAddr <= r_pixAddr + 1'b1;
          r_hsub    <= '0;
        end else begin
          r_hsub <= r_hsub + 1'b1;
        end
        if ({1'b0, w_hcnt} == H_VLAST) begin
          if (r_vsub == SUB_LAST) begin
            r_lineBase <= r_lineBase + LINE_STEP;
            r_vsub     <= '0;
          end else begin
            r_vsub <= r_vsub + 1'b1;
          end
        end
      end
      if (w_lineEnd) begin
        r_pixAddr <= r_lineBase;
        r_hsub    <= '0;
      end
      if (w_frameEnd) begin
        r_lineBase <= '0;
        r_pixAddr  <= '0;
        r_vsub     <= '0;
      end
    end
  end

`ifdef VGA_SCANLINE_EN
  localparam int TAP_W = 4;
  logic [TAP_W-1:0] w_tapIn;
  assign w_tapIn = {w_vcnt[0], w_visible, w_hsAct, w_vsAct};
`else
  localparam int TAP_W = 3;
  logic [TAP_W-1:0] w_tapIn;
  assign w_tapIn = {w_visible, w_hsAct, w_vsAct};
`endif

  // RD_LAT taps plus the pin register give RD_LAT+1 cycles of total latency
  logic [TAP_W-1:0] r_pipe [RD_LAT];
  logic [TAP_W-1:0] w_tapOut;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_tapIn;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tapOut = r_pipe[RD_LAT-1];

  rgb444_t w_pix;
  rgb444_t w_pixOut;
  assign w_pix = fb_data;

`ifdef VGA_SCANLINE_EN
  assign w_pixOut = w_tapOut[3] ? {1'b0, w_pix.r[3:1], 1'b0, w_pix.g[3:1], 1'b0, w_pix.b[3:1]}
                                : w_pix;
`else
  assign w_pixOut = w_pix;
`endif

  rgb444_t r_rgb;
  logic    r_de;
  logic    r_hs;
  logic    r_vs;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_rgb <= '0;
      r_de  <= 1'b0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
    end else begin
      r_de  <= w_tapOut[2];
      r_rgb <= w_tapOut[2] ? w_pixOut : '0;
      r_hs  <= w_tapOut[1] ? HS_POL : ~HS_POL;
      r_vs  <= w_tapOut[0] ? VS_POL : ~VS_POL;
    end
  end

  assign fb_addr     = r_pixAddr;
  assign VGA_R       = r_rgb.r;
  assign VGA_G       = r_rgb.g;
  assign VGA_B       = r_rgb.b;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign de          = r_de;
  assign frame_start = w_frameStart;
  assign line        = 10'(w_vcnt);

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reduced rasters for frame-level checks plus one default 640x480 instance.
module tb_vga_scanout;

  // Small raster: 24 clocks per line, 12 lines per frame
  localparam int SHV = 16, SHF = 2, SHS = 3, SHB = 3, SHT = 24;
  localparam int SVV = 8,  SVF = 1, SVS = 2, SVB = 1, SVT = 12;
  localparam int FRAME = SHT * SVT;
`ifdef VGA_SCANLINE_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  always #5 CLOCK = ~CLOCK;

  logic [16:0] addrA, addrB, addrC, addrD;
  logic [11:0] fbdA = 12'h000;
  logic [11:0] fbdB = 12'h000;
  logic [11:0] fbdC = 12'hFFF;
  logic [11:0] fbdD = 12'h000;
  logic [16:0] memA1 = '0;
  logic [3:0]  rA, gA, bA, rB, gB, bB, rC, gC, bC, rD, gD, bD;
  logic        hsA, vsA, deA, fsA, hsB, vsB, deB, fsB;
  logic        hsC, vsC, deC, fsC, hsD, vsD, deD, fsD;
  logic [9:0]  lineA, lineB, lineC, lineD;

  // Two-cycle framebuffer returning the low 12 address bits as pixel data
  always @(posedge CLOCK) begin
    memA1 <= addrA;
    fbdA  <= memA1[11:0];
  end

  vga_scanout #(.H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                .SCALE(1), .RD_LAT(2)) dutA (
    .CLOCK(CLOCK), .RESET(RESET), .fb_addr(addrA), .fb_data(fbdA),
    .VGA_R(rA), .VGA_G(gA), .VGA_B(bA), .VGA_HS(hsA), .VGA_VS(vsA),
    .de(deA), .frame_start(fsA), .line(lineA));

  vga_scanout #(.H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                .SCALE(2), .RD_LAT(1)) dutB (
    .CLOCK(CLOCK), .RESET(RESET), .fb_addr(addrB), .fb_data(fbdB),
    .VGA_R(rB), .VGA_G(gB), .VGA_B(bB), .VGA_HS(hsB), .VGA_VS(vsB),
    .de(deB), .frame_start(fsB), .line(lineB));

  vga_scanout #(.H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                .SCALE(1), .RD_LAT(1)) dutC (
    .CLOCK(CLOCK), .RESET(RESET), .fb_addr(addrC), .fb_data(fbdC),
    .VGA_R(rC), .VGA_G(gC), .VGA_B(bC), .VGA_HS(hsC), .VGA_VS(vsC),
    .de(deC), .frame_start(fsC), .line(lineC));

  vga_scanout dutD (
    .CLOCK(CLOCK), .RESET(RESET), .fb_addr(addrD), .fb_data(fbdD),
    .VGA_R(rD), .VGA_G(gD), .VGA_B(bD), .VGA_HS(hsD), .VGA_VS(vsD),
    .de(deD), .frame_start(fsD), .line(lineD));

  // Raster position of the small timing at a given cycle index
  function automatic int posH(input int p);
    return p % SHT;
  endfunction
  function automatic int posV(input int p);
    return (p / SHT) % SVT;
  endfunction
  function automatic bit visP(input int p);
    return (p >= 0) && (posH(p) < SHV) && (posV(p) < SVV);
  endfunction
  function automatic bit hsP(input int p);
    return (p >= 0) && (posH(p) >= SHV + SHF) && (posH(p) < SHV + SHF + SHS);
  endfunction
  function automatic bit vsP(input int p);
    return (p >= 0) && (posV(p) >= SVV + SVF) && (posV(p) < SVV + SVF + SVS);
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
    n++;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    #1;
    n = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    checks++;
    if ({hsA, vsA, deA, rA, gA, bA, fsA} !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_pinsA got=%b exp=%b", {hsA, vsA, deA, rA, gA, bA, fsA},
               {1'b1, 1'b1, 1'b0, 12'h000, 1'b0});
    end
    checks++;
    if ({addrA, lineA} !== {17'd0, 10'd0}) begin
      failures++;
      $display("[TB] FAIL reset_cntA addr=%0d line=%0d exp=0/0", addrA, lineA);
    end
    checks++;
    if ({hsD, vsD, deD, rD, gD, bD, fsD} !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_pinsD got=%b", {hsD, vsD, deD, rD, gD, bD, fsD});
    end
    RESET = 1'b0;
    #1;
    n = 0;
    checks++;
    if ({fsA, fsD} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL first_frame_start got=%b exp=11", {fsA, fsD});
    end
    step();
    checks++;
    if ({fsA, fsD} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL frame_start_width got=%b exp=00", {fsA, fsD});
    end
  endtask

  task automatic test_hsync_default();
    int lowCnt;
    int firstLow;
    int deCnt;
    int vsLow;
    lowCnt = 0; firstLow = -1; deCnt = 0; vsLow = 0;
    doReset();
    for (int k = 0; k < 1600; k++) begin
      if (!hsD) begin
        lowCnt++;
        if (firstLow < 0) firstLow = n;
      end
      if (deD) deCnt++;
      if (!vsD) vsLow++;
      if (n == 800) begin
        checks++;
        if (lineD !== 10'd1) begin
          failures++;
          $display("[TB] FAIL line_count got=%0d exp=1", lineD);
        end
      end
      step();
    end
    checks++;
    if (firstLow != 658) begin
      failures++;
      $display("[TB] FAIL hs_first_low got=%0d exp=658", firstLow);
    end
    checks++;
    if (lowCnt != 192) begin
      failures++;
      $display("[TB] FAIL hs_low_cycles got=%0d exp=192", lowCnt);
    end
    checks++;
    if (deCnt != 1280 || vsLow != 0) begin
      failures++;
      $display("[TB] FAIL de_vs_default de=%0d vsLow=%0d exp=1280/0", deCnt, vsLow);
    end
  endtask

  task automatic test_frame_a();
    int p;
    logic expDe, expHs, expVs, expFs;
    logic [11:0] expRgb;
    doReset();
    for (int k = 0; k <= 2 * FRAME; k++) begin
      p = n - 3;
      expDe  = visP(p);
      expHs  = !hsP(p);
      expVs  = !vsP(p);
      expRgb = expDe ? 12'(posV(p) * SHV + posH(p)) : 12'h000;
      expFs  = ((n % FRAME) == 0);
      checks++;
      if ({hsA, vsA, deA, rA, gA, bA} !== {expHs, expVs, expDe, expRgb}) begin
        failures++;
        $display("[TB] FAIL pinsA n=%0d got=%b exp=%b", n, {hsA, vsA, deA, rA, gA, bA},
                 {expHs, expVs, expDe, expRgb});
      end
      checks++;
      if (fsA !== expFs) begin
        failures++;
        $display("[TB] FAIL frame_startA n=%0d got=%b exp=%b", n, fsA, expFs);
      end
      if (visP(n)) begin
        checks++;
        if (addrA !== 17'(posV(n) * SHV + posH(n))) begin
          failures++;
          $display("[TB] FAIL addrA n=%0d got=%0d exp=%0d", n, addrA, posV(n) * SHV + posH(n));
        end
      end
      if (n == 2 || n == 3) begin
        checks++;
        if (deA !== (n == 3)) begin
          failures++;
          $display("[TB] FAIL de_rise n=%0d got=%b", n, deA);
        end
      end
      if (n == 8) begin
        checks++;
        if ({rA, gA, bA} !== 12'h005) begin
          failures++;
          $display("[TB] FAIL pix5 got=%h exp=005", {rA, gA, bA});
        end
      end
      step();
    end
  endtask

  task automatic test_scale2();
    int expA;
    doReset();
    for (int k = 0; k < FRAME; k++) begin
      if (visP(n)) begin
        expA = (posV(n) / 2) * (SHV / 2) + posH(n) / 2;
        checks++;
        if (addrB !== 17'(expA)) begin
          failures++;
          $display("[TB] FAIL addrB n=%0d got=%0d exp=%0d", n, addrB, expA);
        end
      end
      checks++;
      if (deB !== visP(n - 2)) begin
        failures++;
        $display("[TB] FAIL deB n=%0d got=%b exp=%b", n, deB, visP(n - 2));
      end
      if (n == SHT || n == 2 * SHT || n == 7 * SHT + 15) begin
        expA = (n == SHT) ? 0 : (n == 2 * SHT) ? 8 : 31;
        checks++;
        if (addrB !== 17'(expA)) begin
          failures++;
          $display("[TB] FAIL scale2_mark n=%0d got=%0d exp=%0d", n, addrB, expA);
        end
      end
      step();
    end
  endtask

  task automatic test_blank_scanline();
    int p;
    logic expDe;
    logic [11:0] expRgb;
    doReset();
    for (int k = 0; k < FRAME; k++) begin
      p = n - 2;
      expDe  = visP(p);
      expRgb = !expDe ? 12'h000 : (SCAN_EN && (posV(p) % 2 == 1)) ? 12'h777 : 12'hFFF;
      checks++;
      if ({deC, rC, gC, bC} !== {expDe, expRgb}) begin
        failures++;
        $display("[TB] FAIL blankC n=%0d got=%b/%h exp=%b/%h", n, deC, {rC, gC, bC}, expDe, expRgb);
      end
      step();
    end
  endtask

  task automatic test_midreset();
    doReset();
    while (n < 5 * SHT + 7) step();
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    checks++;
    if ({hsA, vsA, deA, rA, gA, bA, fsA} !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midreset_pins got=%b", {hsA, vsA, deA, rA, gA, bA, fsA});
    end
    checks++;
    if ({addrA, lineA} !== {17'd0, 10'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_cnt addr=%0d line=%0d exp=0/0", addrA, lineA);
    end
    RESET = 1'b0;
    #1;
    n = 0;
    checks++;
    if ({fsA, addrA} !== {1'b1, 17'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_restart fs=%b addr=%0d exp=1/0", fsA, addrA);
    end
    step();
    step();
    checks++;
    if (deA !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_pipe_clear got=%b exp=0", deA);
    end
    step();
    checks++;
    if ({deA, rA, gA, bA} !== {1'b1, 12'h000}) begin
      failures++;
      $display("[TB] FAIL midreset_first_pix got=%b/%h exp=1/000", deA, {rA, gA, bA});
    end
  endtask

  initial begin
    test_reset();
    test_hsync_default();
    test_frame_a();
    test_scale2();
    test_blank_scanline();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout n=%0d", n);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Parametrised VGA scan-out engine; successor to the fixed 640x480 `vga` block on the DE0 board top.
- Generates sync and blanking from parameterised timings.
- Reads a linear 12-bit (4:4:4) framebuffer through a fixed-latency read port, with optional integer pixel doubling.
- Aligns RGB, sync and DE at the pins.
- Sits between the PLL pixel clock (clock_25) and VGA_R/G/B/HS/VS.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync lines
V_BP, 33, vertical back porch
HS_POL, 0, HS active level
VS_POL, 0, VS active level
SCALE, 1, pixel/line replication factor (1, 2 or 4); FB is (H_VIS/SCALE) x (V_VIS/SCALE)
RD_LAT, 1, framebuffer read latency in cycles (1..3)
ADDR_W, 17, framebuffer address width

Ports:
CLOCK  in  1  pixel clock
RESET  in  1  synchronous, active-high reset
fb_addr  out  ADDR_W  framebuffer read address
fb_data  in  12  pixel {R,G,B}, valid RD_LAT cycles after fb_addr
VGA_R  out  4  red
VGA_G  out  4  green
VGA_B  out  4  blue
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
de  out  1  data enable, aligned with RGB
frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0, undelayed
line  out  10  current vcnt, undelayed

Behaviour:
- Interface as decided: one clock, CLOCK; reset RESET is synchronous and active-high.
- Counters: H_TOT=H_VIS+H_FP+H_SYNC+H_BP; V_TOT likewise.
  - hcnt counts 0..H_TOT-1 and wraps to 0.
  - vcnt increments on each hcnt wrap and wraps to 0 after V_TOT-1.
- Stage-0 timing: visible when hcnt<H_VIS and vcnt<V_VIS. Sync is active for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); vertical sync is defined the same way on vcnt.
- Address generation is incremental, with no multiplier:
  - Registers line_base and pix_addr, plus sub-counters hsub (0..SCALE-1) and vsub (0..SCALE-1).
  - At hcnt=0: pix_addr<=line_base.
  - Each visible pixel: hsub increments; when hsub=SCALE-1, pix_addr+1 and hsub<=0.
  - At hcnt=H_VIS-1 on a visible line: if vsub=SCALE-1, line_base+=H_VIS/SCALE and vsub<=0; else vsub+1.
  - At vcnt wrap: line_base<=0, vsub<=0.
  - fb_addr=pix_addr; its value is don't-care outside the visible area.
- Pipeline: visible/hs/vs are delayed RD_LAT+1 cycles through a shift register. fb_data is registered into VGA_R/G/B in the same cycle the delayed visible bit is registered into de.
  - Total latency from counter position to pins is RD_LAT+1 cycles.
  - RGB=0 whenever delayed visible=0.
- Reset values: hcnt=vcnt=0; line_base=pix_addr=0; hsub=vsub=0; VGA_R/G/B=0; de=0; VGA_HS=~HS_POL; VGA_VS=~VS_POL; frame_start=0; delay lines cleared to inactive.
- Reset mid-frame: all of the above takes effect on the next edge. The first frame_start pulse comes one cycle after RESET deasserts (hcnt=0, vcnt=0).
- Simultaneous events: at the last pixel of the last visible line, the line_base advance and the vcnt/hcnt updates happen in the same cycle. The frame-wrap reset of line_base takes priority over the advance.
- Parameter check (elaboration-time): H_VIS and V_VIS must be divisible by SCALE, and (H_VIS/SCALE)*(V_VIS/SCALE) must be ≤ 2^ADDR_W.

Optional Feature:
- Macro: VGA_SCANLINE_EN.
- Defined: on output lines with vsub-delayed LSB of the source line row = odd output row (vcnt[0]=1, delayed), each colour channel is output as value>>1 (e.g. 4'hF→4'h7). Sync, de and latency are unchanged.
- Undefined: RGB passes through unmodified and no extra logic is built.

Decomposition:
- Package vga_pkg holds:
  - rgb444_t struct {r,g,b}.
  - Constants for the standard modes: 640x480@60 timings, and the 640x400 DOS variant (V_FP 12, V_SYNC 2, V_BP 35, VS_POL 1).
  - A function computing H_TOT/V_TOT.
- One natural sub-module: vga_timing (counters, raw sync/visible, frame_start). vga_scanout adds address generation and the pipeline around it.

Test Plan:
- Default params, RESET 3 cycles then release → VGA_HS low for exactly 96 cycles per 800-cycle line; VGA_VS low for 2 of 525 lines; frame_start period 420000 cycles.
- RD_LAT=2, memory model returning fb_data=addr[11:0] → first visible pixel of line 0 shows RGB=12'h000 and pixel 5 shows 12'h005, with de rising exactly 3 cycles after hcnt=0.
- SCALE=2 → fb_addr holds each value for 2 cycles. Lines 0 and 1 both start at address 0, line 2 starts at 320, and the last visible pixel is at 76799.
- RESET asserted at vcnt=200, hcnt=300 for 1 cycle → next cycle all outputs are at reset values; fb_addr at the next visible start is 0.
- Blanking region with fb_data forced to 12'hFFF → RGB=0 and de=0 at every hcnt≥H_VIS (delayed), and at every blanked line.
- VGA_SCANLINE_EN defined, fb_data=12'hFFF constant → even output rows show F/F/F and odd rows show 7/7/7. Without the macro, all rows show F/F/F.
